// File: rtl/sequencer_vmondecode_pkg.sv
// Shared definitions for the voltage-monitor filter: ADC channel-to-rail map,
// per-rail state encoding and the rail-count helper.
package sequencer_vmondecode_pkg;

  localparam int unsigned P_MAX_IFNUM = 4;
  localparam int unsigned P_ADC_CHANS = 32;
  localparam logic [7:0]  P_UNMAPPED  = 8'd99;

  typedef enum logic [1:0] {
    RAIL_EMPTY,
    RAIL_VALID,
    RAIL_STALE
  } rail_state_e;

  typedef logic [P_MAX_IFNUM-1:0][P_ADC_CHANS-1:0][7:0] chan_map_t;

  // Channel c maps to rail c on every interface; channel 31 is parked on an
  // unmonitored rail. Values above VRAILS are dropped by the top level.
  function automatic chan_map_t build_chan_map();
    chan_map_t m;
    for (int unsigned i = 0; i < P_MAX_IFNUM; i++) begin
      for (int unsigned c = 0; c < P_ADC_CHANS; c++) begin
        m[i][c] = (c == P_ADC_CHANS - 1) ? P_UNMAPPED : 8'(c);
      end
    end
    return m;
  endfunction

  localparam chan_map_t P_ADC_CHAN_MAP = build_chan_map();

  function automatic int unsigned rail_count(input int unsigned vrails);
    return vrails + 1;
  endfunction

endpackage

// File: rtl/sequencer_vmonfilter_if.sv
// ADC streaming bus: one valid/channel/data lane per ADC interface, no back-pressure.
interface sequencer_vmonfilter_if #(
  parameter int unsigned ADC_IFNUM = 1,
  parameter int unsigned ADC_WIDTH = 12
);
  logic [ADC_IFNUM-1:0]           adc_valid;
  logic [ADC_IFNUM*5-1:0]         adc_channel;
  logic [ADC_IFNUM*ADC_WIDTH-1:0] adc_data;

  modport master (output adc_valid, adc_channel, adc_data);
  modport slave  (input  adc_valid, adc_channel, adc_data);
endinterface

// File: rtl/sequencer_vmon_rail.sv
// One monitored rail: block averager, OV/UV consecutive-sample qualifier,
// stale-data timer and EMPTY/VALID/STALE state.
module sequencer_vmon_rail
  import sequencer_vmondecode_pkg::*;
#(
  parameter int unsigned W          = 12,
  parameter int unsigned AVG_LOG2   = 2,
  parameter int unsigned FAULT_CNT  = 3,
  parameter int unsigned STALE_CLKS = 65535
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_smp_vld,
  input  logic [W-1:0] i_smp_data,
  input  logic         i_mon_en,
  input  logic [W-1:0] i_ov_thr,
  input  logic [W-1:0] i_uv_thr,
  input  logic         i_fault_clr,
  output logic [W+1:0] o_level_q,
  output logic         o_ov_fault,
  output logic         o_uv_fault,
  output logic         o_stale
);

  localparam int unsigned AW = W + AVG_LOG2;
  localparam int unsigned CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int unsigned SW = $clog2(STALE_CLKS + 1);
  localparam logic [CW-1:0] P_LAST      = CW'((1 << AVG_LOG2) - 1);
  localparam logic [SW-1:0] P_STALE_MAX = SW'(STALE_CLKS);
  localparam logic [SW-1:0] P_STALE_PRE = SW'(STALE_CLKS - 1);
  localparam logic [3:0]    P_FAULT_MAX = 4'(FAULT_CNT);

  logic [AW-1:0] r_acc, w_sum;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_level, w_avg;
  logic          r_strobe, w_done, w_timeout, w_valid;
  logic [SW-1:0] r_scnt;
  logic          r_stale;
  logic [3:0]    r_ov_cnt, r_uv_cnt, w_ov_cnt_nxt, w_uv_cnt_nxt;
  logic          r_ov_fault, r_uv_fault, w_ov_set, w_uv_set;
  rail_state_e   r_state, w_state_nxt;

  assign w_sum     = r_acc + AW'(i_smp_data);
  assign w_avg     = W'(w_sum >> AVG_LOG2);
  assign w_done    = i_smp_vld && (r_cnt == P_LAST);
  assign w_timeout = !i_smp_vld && (r_scnt == P_STALE_PRE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_cnt    <= '0;
      r_level  <= '0;
      r_strobe <= 1'b0;
    end else begin
      r_strobe <= w_done;
      if (w_done) begin
        r_acc   <= '0;
        r_cnt   <= '0;
        r_level <= w_avg;
      end else if (i_smp_vld) begin
        r_acc <= w_sum;
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  // A sample landing on the saturating cycle resets the timer before it can fire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scnt  <= '0;
      r_stale <= 1'b0;
    end else if (i_smp_vld) begin
      r_scnt  <= '0;
      r_stale <= 1'b0;
    end else if (r_scnt != P_STALE_MAX) begin
      r_scnt <= r_scnt + SW'(1);
      if (w_timeout) r_stale <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= RAIL_EMPTY;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      RAIL_EMPTY, RAIL_VALID, RAIL_STALE: begin
        if (w_done)         w_state_nxt = RAIL_VALID;
        else if (w_timeout) w_state_nxt = RAIL_STALE;
      end
      default: w_state_nxt = RAIL_EMPTY;
    endcase
  end

  always_comb begin
    w_valid   = (r_state == RAIL_VALID);
    o_level_q = {w_valid, r_strobe, r_level};
    o_stale   = r_stale;
  end

  always_comb begin
    w_ov_cnt_nxt = r_ov_cnt;
    w_uv_cnt_nxt = r_uv_cnt;
    if (!i_mon_en) begin
      w_ov_cnt_nxt = '0;
      w_uv_cnt_nxt = '0;
    end else if (r_strobe) begin
      if (r_level > i_ov_thr)
        w_ov_cnt_nxt = (r_ov_cnt == P_FAULT_MAX) ? r_ov_cnt : r_ov_cnt + 4'd1;
      else
        w_ov_cnt_nxt = '0;
      if (r_level < i_uv_thr)
        w_uv_cnt_nxt = (r_uv_cnt == P_FAULT_MAX) ? r_uv_cnt : r_uv_cnt + 4'd1;
      else
        w_uv_cnt_nxt = '0;
    end
    w_ov_set = i_mon_en && r_strobe && (r_level > i_ov_thr) && (w_ov_cnt_nxt == P_FAULT_MAX);
    w_uv_set = i_mon_en && r_strobe && (r_level < i_uv_thr) && (w_uv_cnt_nxt == P_FAULT_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ov_cnt   <= '0;
      r_uv_cnt   <= '0;
      r_ov_fault <= 1'b0;
      r_uv_fault <= 1'b0;
    end else begin
      r_ov_cnt   <= (i_fault_clr && !w_ov_set) ? '0 : w_ov_cnt_nxt;
      r_uv_cnt   <= (i_fault_clr && !w_uv_set) ? '0 : w_uv_cnt_nxt;
      r_ov_fault <= w_ov_set || (r_ov_fault && !i_fault_clr);
      r_uv_fault <= w_uv_set || (r_uv_fault && !i_fault_clr);
    end
  end

  assign o_ov_fault = r_ov_fault;
  assign o_uv_fault = r_uv_fault;

endmodule

// File: rtl/sequencer_vmonfilter.sv
// ADC-to-rail routing with highest-interface-wins arbitration, feeding one
// averaging/qualifying rail slice per monitored rail (VIN plus VRAILS outputs).
module sequencer_vmonfilter
  import sequencer_vmondecode_pkg::*;
#(
  parameter int unsigned VRAILS     = 4,
  parameter int unsigned ADC_IFNUM  = 1,
  parameter int unsigned ADC_WIDTH  = 12,
  parameter int unsigned AVG_LOG2   = 2,
  parameter int unsigned FAULT_CNT  = 3,
  parameter int unsigned STALE_CLKS = 65535
) (
  input  logic                                   CLOCK,
  input  logic                                   RESET_N,
  sequencer_vmonfilter_if.slave                  adc,
  input  logic [VRAILS:0]                        MON_EN,
  input  logic [(VRAILS+1)*ADC_WIDTH-1:0]        OV_THRESH,
  input  logic [(VRAILS+1)*ADC_WIDTH-1:0]        UV_THRESH,
  input  logic [VRAILS:0]                        FAULT_CLR,
  output logic [(VRAILS+1)*(ADC_WIDTH+2)-1:0]    ADC_LEVEL_Q,
  output logic [VRAILS:0]                        OV_FAULT,
  output logic [VRAILS:0]                        UV_FAULT,
  output logic [VRAILS:0]                        STALE
);

  localparam int unsigned R = rail_count(VRAILS);

  logic [R-1:0]                w_rail_vld;
  logic [R-1:0][ADC_WIDTH-1:0] w_rail_data;

  // Ascending interface scan: the last match, i.e. highest index, overwrites.
  always_comb begin
    w_rail_vld  = '0;
    w_rail_data = '0;
    for (int unsigned r = 0; r < R; r++) begin
      for (int unsigned i = 0; i < ADC_IFNUM; i++) begin
        if (adc.adc_valid[i] &&
            (32'(P_ADC_CHAN_MAP[i][adc.adc_channel[i*5 +: 5]]) == r)) begin
          w_rail_vld[r]  = 1'b1;
          w_rail_data[r] = adc.adc_data[i*ADC_WIDTH +: ADC_WIDTH];
        end
      end
    end
  end

  for (genvar g = 0; g < R; g++) begin : g_rail
    sequencer_vmon_rail #(
      .W          (ADC_WIDTH),
      .AVG_LOG2   (AVG_LOG2),
      .FAULT_CNT  (FAULT_CNT),
      .STALE_CLKS (STALE_CLKS)
    ) u_rail (
      .clk         (CLOCK),
      .rst_n       (RESET_N),
      .i_smp_vld   (w_rail_vld[g]),
      .i_smp_data  (w_rail_data[g]),
      .i_mon_en    (MON_EN[g]),
      .i_ov_thr    (OV_THRESH[g*ADC_WIDTH +: ADC_WIDTH]),
      .i_uv_thr    (UV_THRESH[g*ADC_WIDTH +: ADC_WIDTH]),
      .i_fault_clr (FAULT_CLR[g]),
      .o_level_q   (ADC_LEVEL_Q[g*(ADC_WIDTH+2) +: ADC_WIDTH+2]),
      .o_ov_fault  (OV_FAULT[g]),
      .o_uv_fault  (UV_FAULT[g]),
      .o_stale     (STALE[g])
    );
  end

endmodule
